// File: rtl/brt_usb_20_serial_tx.sv
// USB 2.0 serial transmitter: SYNC, LSB-first data, bit stuffing, NRZI and speed-specific EOP.
// Optional build macro BRT_USB_TX_STUFF_ERR_INJ_EN adds inj_stuff_err to suppress stuffing per packet.
module brt_usb_20_serial_tx #(
    parameter int SYNC_HS_BITS = 32,
    parameter int SYNC_FS_BITS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_tick,
    input  logic [1:0] speed,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
`ifdef BRT_USB_TX_STUFF_ERR_INJ_EN
    input  logic       inj_stuff_err,
`endif
    output logic       tx_ready,
    output logic       tx_dp,
    output logic       tx_dm,
    output logic       tx_en,
    output logic       se0_en,
    output logic       busy,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_HS,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_last_q, hold_last_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] sh_data_q, sh_data_d;
    logic       sh_last_q, sh_last_d;
    logic [5:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] ones_q, ones_d;
    logic       hs_q, hs_d;
    logic       ls_q, ls_d;
    logic       stuff_en_q, stuff_en_d;
    logic       lvl_q, lvl_d;          // current NRZI level, 1 = J
    logic       dp_d, dm_d, en_d, se0_d, underrun_d;

    logic       acc;
    logic       in_eop;
    logic       drive;
    logic       reload;
    logic       byte_end;
    logic       data_bit;
    logic [5:0] sync_end;
    state_t     eop_state;

    // Handshake: a byte moves when tx_valid && tx_ready on a clk edge; tx_valid with
    // tx_ready low is simply held off, never dropped. tx_ready depends only on registers.
    assign in_eop    = (state_q == S_EOP_HS) || (state_q == S_EOP_SE0) || (state_q == S_EOP_J);
    assign tx_ready  = ~hold_full_q & ~in_eop;
    assign acc       = tx_valid & tx_ready;
    assign busy      = (state_q != S_IDLE);
    assign sync_end  = hs_q ? 6'(SYNC_HS_BITS - 1) : 6'(SYNC_FS_BITS - 1);
    assign eop_state = hs_q ? S_EOP_HS : S_EOP_SE0;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        sh_data_d   = sh_data_q;
        sh_last_d   = sh_last_q;
        bit_cnt_d   = bit_cnt_q;
        ones_d      = ones_q;
        hs_d        = hs_q;
        ls_d        = ls_q;
        stuff_en_d  = stuff_en_q;
        lvl_d       = lvl_q;
        dp_d        = tx_dp;
        dm_d        = tx_dm;
        en_d        = tx_en;
        se0_d       = se0_en;
        underrun_d  = 1'b0;
        drive       = 1'b0;
        reload      = 1'b0;
        byte_end    = 1'b0;
        data_bit    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bit_tick) begin
                    if (hold_full_q) begin
                        // First SYNC bit goes out on this tick: a 0 toggles J to K.
                        state_d   = S_SYNC;
                        hs_d      = speed[1];
                        ls_d      = (speed == 2'd0);
`ifdef BRT_USB_TX_STUFF_ERR_INJ_EN
                        stuff_en_d = ~inj_stuff_err;
`else
                        stuff_en_d = 1'b1;
`endif
                        lvl_d     = 1'b0;
                        drive     = 1'b1;
                        bit_cnt_d = 6'd1;
                        ones_d    = 3'd0;
                    end else begin
                        dp_d  = 1'b0;
                        dm_d  = 1'b0;
                        en_d  = 1'b0;
                        se0_d = 1'b0;
                    end
                end
            end
            S_SYNC: begin
                if (bit_tick) begin
                    drive = 1'b1;
                    if (bit_cnt_q == sync_end) begin
                        ones_d    = 3'd1;
                        bit_cnt_d = 6'd0;
                        reload    = 1'b1;
                        state_d   = S_DATA;
                    end else begin
                        lvl_d     = ~lvl_q;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    drive = 1'b1;
                    if (stuff_en_q && (ones_q == 3'd6)) begin
                        lvl_d    = ~lvl_q;
                        ones_d   = 3'd0;
                        byte_end = (bit_cnt_q == 6'd8);
                    end else begin
                        data_bit  = sh_data_q[0];
                        sh_data_d = {1'b0, sh_data_q[7:1]};
                        lvl_d     = data_bit ? lvl_q : ~lvl_q;
                        ones_d    = data_bit ? ones_q + 3'd1 : 3'd0;
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        // A stuff bit owed after bit 7 defers the end-of-byte decision.
                        byte_end  = (bit_cnt_q == 6'd7) && !(stuff_en_q && (ones_d == 3'd6));
                    end
                    if (byte_end) begin
                        bit_cnt_d = 6'd0;
                        if (sh_last_q) begin
                            state_d = eop_state;
                        end else if (hold_full_q || acc) begin
                            reload = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = eop_state;
                        end
                    end
                end
            end
            S_EOP_HS: begin
                if (bit_tick) begin
                    drive    = 1'b1;
                    data_bit = (bit_cnt_q != 6'd0);
                    lvl_d    = data_bit ? lvl_q : ~lvl_q;
                    if (bit_cnt_q == 6'd7) begin
                        bit_cnt_d = 6'd0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_tick) begin
                    dp_d  = 1'b0;
                    dm_d  = 1'b0;
                    en_d  = 1'b0;
                    se0_d = 1'b1;
                    if (bit_cnt_q == 6'd1) begin
                        bit_cnt_d = 6'd0;
                        state_d   = S_EOP_J;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (bit_tick) begin
                    drive     = 1'b1;
                    lvl_d     = 1'b1;
                    bit_cnt_d = 6'd0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drive) begin
            en_d  = 1'b1;
            se0_d = 1'b0;
            dp_d  = lvl_d ^ ls_d;
            dm_d  = ~(lvl_d ^ ls_d);
        end

        // A byte accepted in the reload cycle bypasses the holding register.
        if (reload) begin
            sh_data_d   = hold_full_q ? hold_data_q : tx_data;
            sh_last_d   = hold_full_q ? hold_last_q : tx_last;
            hold_full_d = 1'b0;
        end else if (acc) begin
            hold_data_d = tx_data;
            hold_last_d = tx_last;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_data_q <= 8'd0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            sh_data_q   <= 8'd0;
            sh_last_q   <= 1'b0;
            bit_cnt_q   <= 6'd0;
            ones_q      <= 3'd0;
            hs_q        <= 1'b0;
            ls_q        <= 1'b0;
            stuff_en_q  <= 1'b1;
            lvl_q       <= 1'b1;
            tx_dp       <= 1'b0;
            tx_dm       <= 1'b0;
            tx_en       <= 1'b0;
            se0_en      <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            sh_data_q   <= sh_data_d;
            sh_last_q   <= sh_last_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_q      <= ones_d;
            hs_q        <= hs_d;
            ls_q        <= ls_d;
            stuff_en_q  <= stuff_en_d;
            lvl_q       <= lvl_d;
            tx_dp       <= dp_d;
            tx_dm       <= dm_d;
            tx_en       <= en_d;
            se0_en      <= se0_d;
            underrun    <= underrun_d;
        end
    end

endmodule

// File: tb/tb_brt_usb_20_serial_tx.sv
// Directed bench for brt_usb_20_serial_tx: whole packets are compared as bit-time line strings
// (J, K, 0 = SE0), plus hand-written latency and mid-packet reset sequences.
module tb_brt_usb_20_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_tick = 1'b0;
    logic [1:0] speed = 2'd1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_last = 1'b0;
`ifdef BRT_USB_TX_STUFF_ERR_INJ_EN
    logic       inj_stuff_err = 1'b0;
`endif
    logic       tx_ready, tx_dp, tx_dm, tx_en, se0_en, busy, underrun;

    brt_usb_20_serial_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_tick (bit_tick),
        .speed    (speed),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
`ifdef BRT_USB_TX_STUFF_ERR_INJ_EN
        .inj_stuff_err (inj_stuff_err),
`endif
        .tx_ready (tx_ready),
        .tx_dp    (tx_dp),
        .tx_dm    (tx_dm),
        .tx_en    (tx_en),
        .se0_en   (se0_en),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] spd;
        int         div;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       last;
        logic       chg_spd;
        logic       inj;
        int         exp_under;
        string      exp_line;
    } vec_t;

    vec_t vecs[8];
    int   n_vec;
    int   total;
    int   bad;

    logic [7:0] feed_bytes[3];
    int         feed_n;
    int         feed_idx;
    logic       feed_last;
    int         under_cnt;
    int         eop_ready_bad;

    task automatic add_vec(input string name, input logic [1:0] spd, input int div,
                           input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                           input logic last, input logic chg_spd, input logic inj,
                           input int exp_under, input string exp_line);
        vecs[n_vec].name      = name;
        vecs[n_vec].spd       = spd;
        vecs[n_vec].div       = div;
        vecs[n_vec].nbytes    = nbytes;
        vecs[n_vec].b0        = b0;
        vecs[n_vec].b1        = b1;
        vecs[n_vec].last      = last;
        vecs[n_vec].chg_spd   = chg_spd;
        vecs[n_vec].inj       = inj;
        vecs[n_vec].exp_under = exp_under;
        vecs[n_vec].exp_line  = exp_line;
        n_vec++;
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    // One clk: drive inputs after the falling edge, sample once the next falling edge arrives.
    task automatic clk_cycle(input logic tick);
        logic acc;
        bit_tick = tick;
        if (feed_idx < feed_n) begin
            tx_valid = 1'b1;
            tx_data  = feed_bytes[feed_idx];
            tx_last  = feed_last && (feed_idx == feed_n - 1);
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'd0;
            tx_last  = 1'b0;
        end
        acc = tx_valid && tx_ready;
        @(posedge clk);
        if (acc) feed_idx++;
        @(negedge clk);
        if (underrun) under_cnt++;
        if (se0_en && tx_ready) eop_ready_bad++;
    endtask

    function automatic byte line_char(input logic [1:0] spd);
        if (!tx_en && !se0_en && !tx_dp && !tx_dm) return "I";
        if (se0_en && !tx_en && !tx_dp && !tx_dm) return "0";
        if (tx_en && !se0_en && (tx_dp != tx_dm)) return (tx_dp ^ (spd == 2'd0)) ? "J" : "K";
        return "?";
    endfunction

    task automatic run_vec(input vec_t v);
        string got;
        byte   c;
        int    started;
        int    done;
        int    ticks;
        got       = "";
        started   = 0;
        done      = 0;
        ticks     = 0;
        speed     = v.spd;
`ifdef BRT_USB_TX_STUFF_ERR_INJ_EN
        inj_stuff_err = v.inj;
`endif
        feed_bytes[0] = v.b0;
        feed_bytes[1] = v.b1;
        feed_n        = v.nbytes;
        feed_idx      = 0;
        feed_last     = v.last;
        under_cnt     = 0;
        eop_ready_bad = 0;
        while (!done && ticks < 200) begin
            clk_cycle(1'b1);
            ticks++;
            c = line_char(v.spd);
            if (c != "I") begin
                started = 1;
                got = $sformatf("%s%c", got, c);
                if (v.chg_spd) speed = (v.spd == 2'd0) ? 2'd1 : 2'd0;
            end else if (started != 0) begin
                done = 1;
            end
            for (int k = 1; k < v.div; k++) clk_cycle(1'b0);
        end
        check_str({v.name, "_line"}, got, v.exp_line);
        check_val({v.name, "_underrun"}, 8'(under_cnt), 8'(v.exp_under));
        check_val({v.name, "_ready_in_eop"}, 8'(eop_ready_bad), 8'd0);
        check_val({v.name, "_end_busy_ready"}, {6'd0, busy, tx_ready}, 8'b01);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        n_vec     = 0;
        feed_n    = 0;
        feed_idx  = 0;
        feed_last = 1'b0;

        add_vec("fs_a5", 2'd1, 4, 1, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 0,
                "KJKJKJKKKJJKJJKK00J");
        add_vec("fs_ff", 2'd1, 2, 1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 0,
                "KJKJKJKKKKKKKJJJJ00J");
        add_vec("hs_00_80", 2'd2, 1, 2, 8'h00, 8'h80, 1'b1, 1'b0, 1'b0, 0,
                {"KJKJKJKJKJKJKJKJKJKJKJKJKJKJKJKK", "JKJKJKJK", "JKJKJKJJ", "KKKKKKKK"});
        add_vec("ls_3c_underrun", 2'd0, 3, 1, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1,
                "KJKJKJKKJKKKKKJK00J");
        add_vec("fs_f0_ff_spdchg", 2'd1, 1, 2, 8'hF0, 8'hFF, 1'b1, 1'b1, 1'b0, 0,
                {"KJKJKJKK", "JKJKKKKK", "KKJJJJJJJK", "00J"});
        add_vec("hs3_00", 2'd3, 1, 1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0,
                {"KJKJKJKJKJKJKJKJKJKJKJKJKJKJKJKK", "JKJKJKJK", "JJJJJJJJ"});
`ifdef BRT_USB_TX_STUFF_ERR_INJ_EN
        add_vec("fs_ff_inj", 2'd1, 2, 1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 0,
                "KJKJKJKKKKKKKKKK00J");
`endif

        // Reset values.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_line", {4'd0, tx_dp, tx_dm, tx_en, se0_en}, 8'd0);
        check_val("reset_ctrl", {5'd0, busy, underrun, tx_ready}, 8'b001);
        rst_n = 1'b1;
        @(negedge clk);

        // Accept-to-first-SYNC-bit latency: nothing moves until a tick, then K one clk later.
        speed         = 2'd1;
        feed_bytes[0] = 8'hA5;
        feed_n        = 1;
        feed_idx      = 0;
        feed_last     = 1'b1;
        repeat (3) clk_cycle(1'b0);
        check_val("lat_pre_tick", {5'd0, tx_en, busy, tx_ready}, 8'b000);
        clk_cycle(1'b1);
        check_val("lat_first_k", {4'd0, tx_en, tx_dp, tx_dm, busy}, 8'b1011);
        for (int i = 0; i < 60; i++) begin
            if (!busy && !tx_en) break;
            clk_cycle(1'b1);
        end
        check_val("lat_drained", {6'd0, busy, tx_en}, 8'd0);

        for (int i = 0; i < n_vec; i++) run_vec(vecs[i]);

        // Reset while the second byte is on the line, then a clean packet.
        speed         = 2'd1;
        feed_bytes[0] = 8'h55;
        feed_bytes[1] = 8'h33;
        feed_bytes[2] = 8'h0F;
        feed_n        = 3;
        feed_idx      = 0;
        feed_last     = 1'b1;
        for (int i = 0; i < 20; i++) begin
            clk_cycle(1'b1);
            clk_cycle(1'b0);
        end
        check_val("rst_mid_busy", {7'd0, busy}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_mid_line", {4'd0, tx_dp, tx_dm, tx_en, se0_en}, 8'd0);
        check_val("rst_mid_ctrl", {5'd0, busy, underrun, tx_ready}, 8'b001);
        feed_n   = 0;
        feed_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
